// File: rtl/tt_pkg.sv
// Truth-table capture shared types.
// State encoding, vector sizing and code bit mapping.
package tt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } tt_state_e;

  localparam int N_VECTORS = 8;
  localparam int IDX_W     = 3;

  // Input index i lands in code bit 7-i (Wolfram ordering).
  function automatic logic [IDX_W-1:0] wolfram_bit(
    input logic [IDX_W-1:0] idx
  );
    return IDX_W'(N_VECTORS - 1) - idx;
  endfunction

endpackage

// File: rtl/tt_sync.sv
// Gate output synchronizer.
// STAGES-deep flop chain; depth 0 is a wire.
module tt_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_chain
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the observed value one stage per clock.
    always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    // Chain flops clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
  end

endmodule

// File: rtl/truth_table_capture.sv
// Truth-table capture harness.
// Sweeps a 3-input gate and assembles its Wolfram code.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       match,
  output logic       aborted
);

  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(N_VECTORS - 1);

  tt_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       code_q, code_d;
  logic             match_q, match_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abt_q, abt_d;
  logic             sync_out;

  tt_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (gate_out),
    .q    (sync_out)
  );

  // Sweep sequencing, sampling and run outcome.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    code_d  = code_q;
    match_d = match_q;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          code_d  = '0;
          idx_d   = '0;
          vec_d   = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        cnt_d   = CNT_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        code_d[wolfram_bit(idx_q)] = sync_out;
        if (idx_q == IDX_LAST) begin
          vec_d   = '0;
          done_d  = 1'b1;
          match_d = (code_d == exp_q);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          vec_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      vec_d   = '0;
      code_d  = code_q;
      match_d = 1'b0;
      done_d  = 1'b0;
      abt_d   = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  // All harness state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      code_q  <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      code_q  <= code_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  assign in1     = vec_q[2];
  assign in2     = vec_q[1];
  assign in3     = vec_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign code    = code_q;
  assign match   = match_q;
  assign aborted = abt_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture.
// Timeline model plus directed runs on three configurations.
module tb_truth_table_capture;

  localparam int S0 = 4;
  localparam int Y0 = 2;
  localparam int P0 = S0 + Y0 + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic in1, in2, in3, gate_out;
  logic busy, done, match, aborted;
  logic [7:0] code;
  logic [7:0] gate_tt = 8'h3E;

  logic start_x = 1'b0;
  logic [7:0] exp_x = 8'h00;
  logic in1_f, in2_f, in3_f, busy_f, done_f, match_f, abt_f;
  logic in1_s, in2_s, in3_s, busy_s, done_s, match_s, abt_s;
  logic [7:0] code_f, code_s;
  logic f_d1 = 0, f_d2 = 0, f_d3 = 0;
  logic s_d1 = 0, s_d2 = 0, s_d3 = 0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign gate_out = gate_tt[3'd7 - {in1, in2, in3}];

  always @(posedge clk) begin
    f_d1 <= gate_tt[3'd7 - {in1_f, in2_f, in3_f}];
    f_d2 <= f_d1;
    f_d3 <= f_d2;
    s_d1 <= gate_tt[3'd7 - {in1_s, in2_s, in3_s}];
    s_d2 <= s_d1;
    s_d3 <= s_d2;
  end

  truth_table_capture u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .in1(in1), .in2(in2), .in3(in3),
    .gate_out(gate_out), .busy(busy), .done(done), .code(code),
    .match(match), .aborted(aborted)
  );

  truth_table_capture #(.SETTLE_CYCLES(1), .SYNC_STAGES(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_x), .abort(1'b0),
    .expected(exp_x), .in1(in1_f), .in2(in2_f), .in3(in3_f),
    .gate_out(f_d3), .busy(busy_f), .done(done_f), .code(code_f),
    .match(match_f), .aborted(abt_f)
  );

  truth_table_capture #(.SETTLE_CYCLES(4), .SYNC_STAGES(0)) u_slow (
    .clk(clk), .rst_n(rst_n), .start(start_x), .abort(1'b0),
    .expected(exp_x), .in1(in1_s), .in2(in2_s), .in3(in3_s),
    .gate_out(s_d3), .busy(busy_s), .done(done_s), .code(code_s),
    .match(match_s), .aborted(abt_s)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Value seen for vector i: the gate sees the inputs as they were
  // S+1-dly cycles into the vector window (earlier = previous vector).
  function automatic logic model_bit(input int s, input int dly,
                                     input int i, input logic [7:0] tt);
    int off, v;
    off = s + 1 - dly;
    if (off >= 0) v = i;
    else v = (i == 0) ? 0 : i - 1;
    return tt[7 - v];
  endfunction

  function automatic logic [7:0] model_code(input int s, input int dly,
                                            input logic [7:0] tt);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c[7 - i] = model_bit(s, dly, i, tt);
    return c;
  endfunction

  // Timeline model of the default instance: t counts cycles since
  // the accepted start; vector i owns t in [iP+1,(i+1)P].
  logic m_run = 0;
  int m_t = 0;
  logic [7:0] m_exp = 0, m_code = 0;
  logic m_match = 0, m_done = 0, m_abt = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] nc;
    int i;
    if (!rst_n) begin
      m_run <= 0; m_t <= 0; m_exp <= 0; m_code <= 0;
      m_match <= 0; m_done <= 0; m_abt <= 0;
    end else begin
      m_done <= 0;
      m_abt  <= 0;
      if (!m_run) begin
        if (start) begin
          m_run <= 1; m_t <= 1; m_exp <= expected; m_code <= 0;
        end
      end else if (abort) begin
        m_run <= 0; m_abt <= 1; m_match <= 0;
      end else begin
        if (m_t % P0 == 0 && m_t <= 8 * P0) begin
          i = m_t / P0 - 1;
          nc = m_code;
          nc[7 - i] = model_bit(S0, 0, i, gate_tt);
          m_code <= nc;
          if (i == 7) begin
            m_done  <= 1;
            m_match <= (nc == m_exp);
          end
        end
        if (m_t == 8 * P0 + 1) m_run <= 0;
        else m_t <= m_t + 1;
      end
    end
  end

  // Per-cycle compare of the default instance against the model.
  always @(negedge clk) begin
    int ev;
    ev = (m_run && m_t <= 8 * P0) ? (m_t - 1) / P0 : 0;
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("aborted", aborted, m_abt);
    chk("inputs", {in1, in2, in3}, ev[2:0]);
    chk("code", code, m_code);
    chk("match", match, m_match);
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] e);
    expected = e;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 300) begin
      tick;
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n, dc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_code", code, 8'h00);
    chk("rst_in", {in1, in2, in3}, 3'b000);
    rst_n = 1;
    tick;

    // 1: matching run, latency counted with the start cycle as cycle 1
    start_run(8'h3E);
    wait_done(1, n);
    chk("t1_latency", n + 1, 66);
    chk("t1_code", code, 8'h3E);
    chk("t1_match", match, 1);
    tick;

    // 2: mismatching expected, single done pulse
    dc = done_cnt;
    start_run(8'h3F);
    wait_done(1, n);
    chk("t2_code", code, 8'h3E);
    chk("t2_match", match, 0);
    repeat (5) tick;
    chk("t2_done_once", done_cnt - dc, 1);

    // 3: slow gate, short settle corrupts; longer settle recovers
    exp_x = 8'h3E;
    start_x = 1;
    tick;
    start_x = 0;
    n = 1;
    while (done_f !== 1'b1 && n < 200) begin tick; n++; end
    chk("t3_fast_done", done_f, 1);
    chk("t3_fast_code", code_f, model_code(1, 3, gate_tt));
    chk("t3_fast_lit", code_f, 8'h1F);
    chk("t3_fast_bad", code_f != 8'h3E, 1);
    chk("t3_fast_match", match_f, 0);
    while (done_s !== 1'b1 && n < 200) begin tick; n++; end
    chk("t3_slow_done", done_s, 1);
    chk("t3_slow_code", code_s, model_code(4, 3, gate_tt));
    chk("t3_slow_lit", code_s, 8'h3E);
    chk("t3_slow_match", match_s, 1);
    tick;

    // 4: abort during SETTLE of index 4
    dc = done_cnt;
    start_run(8'h3E);
    repeat (34) tick;
    abort = 1;
    tick;
    abort = 0;
    chk("t4_aborted", aborted, 1);
    chk("t4_busy", busy, 0);
    chk("t4_code", code, 8'h30);
    chk("t4_match", match, 0);
    chk("t4_in", {in1, in2, in3}, 3'b000);
    tick;
    chk("t4_abt_pulse", aborted, 0);
    repeat (80) tick;
    chk("t4_no_done", done_cnt - dc, 0);

    // 5: second start during index 2 is ignored
    start_run(8'h3E);
    repeat (18) tick;
    expected = 8'h00;
    start = 1;
    tick;
    start = 0;
    expected = 8'hFF;
    wait_done(20, n);
    chk("t5_latency", n + 1, 66);
    chk("t5_code", code, 8'h3E);
    chk("t5_match", match, 1);
    tick;

    // 6: reset during SAMPLE of index 5
    start_run(8'h3E);
    repeat (47) tick;
    #2;
    rst_n = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_code", code, 8'h00);
    chk("t6_match", match, 0);
    chk("t6_aborted", aborted, 0);
    chk("t6_in", {in1, in2, in3}, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    tick;
    start_run(8'h3E);
    wait_done(1, n);
    chk("t6_latency", n + 1, 66);
    chk("t6_code2", code, 8'h3E);
    chk("t6_match2", match, 1);
    repeat (3) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
